// File: rtl/ftdnn_pkg.sv
// Shared definitions for the ftdnn datapath: feeder state encoding and the
// burst-length counter width derived from the instruction field widths.
package ftdnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } feed_state_e;

    // Wide enough for tn*tp*n_tile without overflow.
    function automatic int act_len_width(input int wid_tn, input int wid_tp, input int n_tile);
        return wid_tn + wid_tp + $clog2(n_tile);
    endfunction

endpackage

// File: rtl/act_addr_gen.sv
// Activation buffer address generator: running base, beat counter within the
// current burst, modulo-depth address adder and last-beat detection.
module act_addr_gen
    import ftdnn_pkg::*;
#(
    parameter int WID_ACTADDR = 6,
    parameter int WID_LEN     = act_len_width(4, 5, 4)
) (
    input  logic                   clk_l,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   advance,
    input  logic                   clear,
    input  logic [WID_LEN-1:0]     len,
    output logic                   done,
    output logic                   rd_en,
    output logic [WID_ACTADDR-1:0] addr
);

    logic [WID_ACTADDR-1:0] base_q, base_d;
    logic [WID_LEN-1:0]     beat_q, beat_d;
    logic                   run_q, run_d;

    always_comb begin
        done   = run_q && (beat_q == (len - WID_LEN'(1)));
        run_d  = run_q;
        beat_d = beat_q;
        base_d = base_q;
        if (start) begin
            run_d  = 1'b1;
            beat_d = '0;
        end else if (run_q) begin
            beat_d = beat_q + WID_LEN'(1);
            if (done) begin
                run_d = 1'b0;
            end
        end
        // A configuration change restarts the buffer walk from address 0.
        if (clear) begin
            base_d = '0;
        end else if (advance) begin
            base_d = base_q + WID_ACTADDR'(len);
        end
    end

    assign rd_en = run_q;
    assign addr  = base_q + WID_ACTADDR'(beat_q);

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            beat_q <= '0;
            run_q  <= 1'b0;
        end else begin
            base_q <= base_d;
            beat_q <= beat_d;
            run_q  <= run_d;
        end
    end

endmodule

// File: rtl/act_feeder.sv
// Streams one sblk instruction's activations per request edge from the
// activation buffer. Optional burst counter: ACT_FEEDER_PERF_CNT_EN.
module act_feeder
    import ftdnn_pkg::*;
#(
    parameter int N_TILE      = 4,
    parameter int WID_ACT     = 16,
    parameter int WID_ACTADDR = 6,
    parameter int WID_INST_TN = 4,
    parameter int WID_INST_TP = 5,
    parameter int WID_LEN     = act_len_width(WID_INST_TN, WID_INST_TP, N_TILE)
) (
    input  logic                   clk_l,
    input  logic                   rst_n,
    input  logic                   inst_en,
    input  logic [WID_INST_TN-1:0] inst_tn,
    input  logic [WID_INST_TP-1:0] inst_tp,
    input  logic                   act_data_in_req,
    output logic                   mem_rd_en,
    output logic [WID_ACTADDR-1:0] mem_rd_addr,
    input  logic [2*WID_ACT-1:0]   mem_rd_data,
    output logic                   act_data_out_vld,
    output logic [2*WID_ACT-1:0]   act_data_out,
    output logic                   busy,
    output logic                   cfg_err
`ifdef ACT_FEEDER_PERF_CNT_EN
    ,
    output logic [15:0]            burst_cnt
`endif
);

    function automatic logic [WID_LEN-1:0] burst_len(input logic [WID_INST_TN-1:0] tn,
                                                     input logic [WID_INST_TP-1:0] tp);
        return WID_LEN'(tn) * WID_LEN'(tp) * WID_LEN'(N_TILE);
    endfunction

    feed_state_e            state_q, state_d;
    logic                   req_q, req_d;
    logic [WID_INST_TN-1:0] tn_q, tn_d, pend_tn_q, pend_tn_d;
    logic [WID_INST_TP-1:0] tp_q, tp_d, pend_tp_q, pend_tp_d;
    logic                   pend_vld_q, pend_vld_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic                   vld_q, vld_d;
    logic [2*WID_ACT-1:0]   data_q, data_d;
`ifdef ACT_FEEDER_PERF_CNT_EN
    logic [15:0]            cnt_q, cnt_d;
`endif

    logic               start, advance, base_clr, done, rd_en;
    logic [WID_LEN-1:0] len_act, len_idle;
    logic               req_rise;

    assign req_rise = act_data_in_req & ~req_q;
    assign len_act  = burst_len(tn_q, tp_q);
    // In IDLE a same-cycle inst_en takes effect before the request is judged.
    assign len_idle = burst_len(inst_en ? inst_tn : tn_q, inst_en ? inst_tp : tp_q);

    always_comb begin
        state_d    = state_q;
        req_d      = act_data_in_req;
        tn_d       = tn_q;
        tp_d       = tp_q;
        pend_vld_d = pend_vld_q;
        pend_tn_d  = pend_tn_q;
        pend_tp_d  = pend_tp_q;
        busy_d     = busy_q;
        err_d      = err_q;
        start      = 1'b0;
        advance    = 1'b0;
        base_clr   = 1'b0;
        vld_d      = rd_en;
        data_d     = rd_en ? mem_rd_data : data_q;
`ifdef ACT_FEEDER_PERF_CNT_EN
        cnt_d      = cnt_q;
`endif
        if (inst_en) begin
            err_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (inst_en) begin
                    tn_d     = inst_tn;
                    tp_d     = inst_tp;
                    base_clr = 1'b1;
                end
                if (req_rise) begin
                    if (len_idle != '0) begin
                        start   = 1'b1;
                        busy_d  = 1'b1;
                        state_d = READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (inst_en) begin
                    pend_tn_d  = inst_tn;
                    pend_tp_d  = inst_tp;
                    pend_vld_d = 1'b1;
                end
                if (done) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                advance = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef ACT_FEEDER_PERF_CNT_EN
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
                if (inst_en) begin
                    tn_d       = inst_tn;
                    tp_d       = inst_tp;
                    base_clr   = 1'b1;
                    pend_vld_d = 1'b0;
                end else if (pend_vld_q) begin
                    tn_d       = pend_tn_q;
                    tp_d       = pend_tp_q;
                    base_clr   = 1'b1;
                    pend_vld_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    act_addr_gen #(
        .WID_ACTADDR (WID_ACTADDR),
        .WID_LEN     (WID_LEN)
    ) u_addr_gen (
        .clk_l   (clk_l),
        .rst_n   (rst_n),
        .start   (start),
        .advance (advance),
        .clear   (base_clr),
        .len     (len_act),
        .done    (done),
        .rd_en   (rd_en),
        .addr    (mem_rd_addr)
    );

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            tn_q       <= '0;
            tp_q       <= '0;
            pend_vld_q <= 1'b0;
            pend_tn_q  <= '0;
            pend_tp_q  <= '0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            vld_q      <= 1'b0;
            data_q     <= '0;
`ifdef ACT_FEEDER_PERF_CNT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            tn_q       <= tn_d;
            tp_q       <= tp_d;
            pend_vld_q <= pend_vld_d;
            pend_tn_q  <= pend_tn_d;
            pend_tp_q  <= pend_tp_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            vld_q      <= vld_d;
            data_q     <= data_d;
`ifdef ACT_FEEDER_PERF_CNT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign mem_rd_en        = rd_en;
    assign act_data_out_vld = vld_q;
    assign act_data_out     = data_q;
    assign busy             = busy_q;
    assign cfg_err          = err_q;
`ifdef ACT_FEEDER_PERF_CNT_EN
    assign burst_cnt        = cnt_q;
`endif

endmodule

// File: tb/tb_act_feeder.sv
// Self-checking bench for act_feeder: buffer model, address/data scoreboard,
// per-burst timing checks and configuration/reset corner cases.
module tb_act_feeder;

    localparam int N_TILE      = 4;
    localparam int WID_ACT     = 16;
    localparam int WID_ACTADDR = 6;
    localparam int WID_INST_TN = 4;
    localparam int WID_INST_TP = 5;
    localparam int DEPTH       = 1 << WID_ACTADDR;
    localparam int W           = 2 * WID_ACT;

    logic                   clk_l = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   inst_en = 1'b0;
    logic [WID_INST_TN-1:0] inst_tn = '0;
    logic [WID_INST_TP-1:0] inst_tp = '0;
    logic                   act_data_in_req = 1'b0;
    logic                   mem_rd_en;
    logic [WID_ACTADDR-1:0] mem_rd_addr;
    logic [W-1:0]           mem_rd_data;
    logic                   act_data_out_vld;
    logic [W-1:0]           act_data_out;
    logic                   busy;
    logic                   cfg_err;
`ifdef ACT_FEEDER_PERF_CNT_EN
    logic [15:0]            burst_cnt;
`endif

    logic [W-1:0]           mem [DEPTH];
    logic [W-1:0]           exp_q[$];
    logic [WID_ACTADDR-1:0] addr_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int m_tn, m_tp, m_base, m_bursts;
    bit m_err;

    always #5 clk_l = ~clk_l;

    // Activation buffer: combinational read, captured by the DUT's output register.
    assign mem_rd_data = mem_rd_en ? mem[mem_rd_addr] : '0;

    act_feeder #(
        .N_TILE      (N_TILE),
        .WID_ACT     (WID_ACT),
        .WID_ACTADDR (WID_ACTADDR),
        .WID_INST_TN (WID_INST_TN),
        .WID_INST_TP (WID_INST_TP)
    ) dut (
        .clk_l            (clk_l),
        .rst_n            (rst_n),
        .inst_en          (inst_en),
        .inst_tn          (inst_tn),
        .inst_tp          (inst_tp),
        .act_data_in_req  (act_data_in_req),
        .mem_rd_en        (mem_rd_en),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_data      (mem_rd_data),
        .act_data_out_vld (act_data_out_vld),
        .act_data_out     (act_data_out),
        .busy             (busy),
        .cfg_err          (cfg_err)
`ifdef ACT_FEEDER_PERF_CNT_EN
        ,
        .burst_cnt        (burst_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every read strobe and every output beat must match the next expectation.
    always @(negedge clk_l) begin
        if (rst_n) begin
            if (mem_rd_en) begin
                check("rd_pending", addr_q.size() != 0, 1);
                if (addr_q.size() != 0) check("rd_addr", mem_rd_addr, addr_q.pop_front());
            end
            if (act_data_out_vld) begin
                check("vld_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("beat_data", act_data_out, exp_q.pop_front());
            end
        end
    end

    task automatic push_burst(input int len);
        for (int i = 0; i < len; i++) begin
            addr_q.push_back(WID_ACTADDR'((m_base + i) % DEPTH));
            exp_q.push_back(mem[(m_base + i) % DEPTH]);
        end
    endtask

    task automatic cfg(input int tn, input int tp);
        @(negedge clk_l);
        inst_en = 1'b1;
        inst_tn = WID_INST_TN'(tn);
        inst_tp = WID_INST_TP'(tp);
        @(negedge clk_l);
        inst_en = 1'b0;
        m_tn = tn; m_tp = tp; m_base = 0; m_err = 1'b0;
    endtask

    task automatic burst(input int drop_k, input int rise_k, input bit sim_cfg,
                         input bit mid_cfg, input int ctn, input int ctp);
        int len, n_rd, n_vld, n_busy, f_rd, f_vld;
        n_rd = 0; n_vld = 0; n_busy = 0; f_rd = 0; f_vld = 0;
        if (sim_cfg) begin
            inst_en = 1'b1;
            inst_tn = WID_INST_TN'(ctn);
            inst_tp = WID_INST_TP'(ctp);
            m_tn = ctn; m_tp = ctp; m_base = 0; m_err = 1'b0;
        end
        len = m_tn * m_tp * N_TILE;
        push_burst(len);
        act_data_in_req = 1'b1;
        for (int k = 1; k <= len + 4; k++) begin
            @(negedge clk_l);
            if (k == 1) inst_en = 1'b0;
            if (mem_rd_en) begin n_rd++; if (f_rd == 0) f_rd = k; end
            if (act_data_out_vld) begin n_vld++; if (f_vld == 0) f_vld = k; end
            if (busy) n_busy++;
            if (k == drop_k) act_data_in_req = 1'b0;
            if (k == rise_k) act_data_in_req = 1'b1;
            if (mid_cfg && k == 5) begin
                inst_en = 1'b1;
                inst_tn = WID_INST_TN'(ctn);
                inst_tp = WID_INST_TP'(ctp);
            end
            if (mid_cfg && k == 6) inst_en = 1'b0;
        end
        if (len == 0) begin
            m_err = 1'b1;
            check("zero_rd_cnt", n_rd, 0);
            check("zero_busy_cnt", n_busy, 0);
        end else begin
            check("first_rd", f_rd, 1);
            check("first_vld", f_vld, 2);
            check("rd_cnt", n_rd, len);
            check("vld_cnt", n_vld, len);
            check("busy_cnt", n_busy, len + 1);
            m_base = (m_base + len) % DEPTH;
            if (m_bursts < 16'hFFFF) m_bursts++;
        end
        if (mid_cfg) begin
            m_tn = ctn; m_tp = ctp; m_base = 0; m_err = 1'b0;
        end
        check("sb_drained", exp_q.size() + addr_q.size(), 0);
        check("cfg_err", cfg_err, m_err);
        check("busy_idle", busy, 0);
`ifdef ACT_FEEDER_PERF_CNT_EN
        check("burst_cnt", burst_cnt, m_bursts);
`endif
        act_data_in_req = 1'b0;
        @(negedge clk_l);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"}, mem_rd_en, 0);
        check({tag, "_rd_addr"}, mem_rd_addr, 0);
        check({tag, "_vld"}, act_data_out_vld, 0);
        check({tag, "_data"}, act_data_out, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cfg_err"}, cfg_err, 0);
`ifdef ACT_FEEDER_PERF_CNT_EN
        check({tag, "_burst_cnt"}, burst_cnt, 0);
`endif
    endtask

    task automatic reset_mid();
        push_burst(m_tn * m_tp * N_TILE);
        act_data_in_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_l);
            if (k == 1) act_data_in_req = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("rst_mid");
        exp_q.delete();
        addr_q.delete();
        m_tn = 0; m_tp = 0; m_base = 0; m_err = 1'b0; m_bursts = 0;
        @(negedge clk_l);
        rst_n = 1'b1;
        @(negedge clk_l);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom);
        m_tn = 0; m_tp = 0; m_base = 0; m_err = 1'b0; m_bursts = 0;
        repeat (3) @(negedge clk_l);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk_l);

        cfg(2, 2);
        burst(1, 0, 1'b0, 1'b0, 0, 0);                      // 0..15
        burst(1, 0, 1'b0, 1'b0, 0, 0);                      // 16..31
        burst(1, 0, 1'b1, 1'b0, 2, 3);                      // inst_en with edge: 24 from 0
        burst(1, 0, 1'b0, 1'b0, 0, 0);                      // 24..47
        burst(1, 0, 1'b0, 1'b0, 0, 0);                      // 48..63 then 0..7

        cfg(2, 2);
        burst(2, $urandom_range(4, 12), 1'b0, 1'b1, 2, 3);  // re-raised req ignored, pending 2x3
        burst(1, 0, 1'b0, 1'b0, 0, 0);                      // 24 from 0

        cfg(0, 2);
        burst(1, 0, 1'b0, 1'b0, 0, 0);
        repeat (3) @(negedge clk_l);
        check("cfg_err_sticky", cfg_err, 1);
        cfg(2, 2);
        check("cfg_err_clear", cfg_err, 0);

        reset_mid();
        cfg(2, 2);
        burst(3, 0, 1'b0, 1'b0, 0, 0);                      // held req, dropped at beat 3

        check("sb_final", exp_q.size() + addr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
